// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC datapath family, including the
// sequential divider's state encoding and divide-by-zero result.
package mac_pkg;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'd0,
        DIV_ST_RUN  = 2'd1,
        DIV_ST_DONE = 2'd2
    } div_state_t;

    localparam logic [15:0] DIV_ZERO_QUOT = 16'hFFFF;

    // Width of the shared prefix subtractor; divider operands are zero-extended to it.
    localparam int SUB_W = 16;

endpackage

// File: rtl/bk_sub_16.sv
// 16-bit Brent-Kung subtractor: a + ~b + 1 through a prefix carry network.
// borrow_n is the carry out, high when a >= b (no borrow).
module bk_sub_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] diff,
    output logic        borrow_n
);

    always_comb begin
        logic [15:0] bn;
        logic [15:0] p;
        logic [15:0] gp;
        logic [15:0] pp;

        bn = ~b;
        p  = a ^ bn;
        gp = a & bn;
        pp = p;
        // Fold cin=1 into bit 0 so every prefix group ending at bit 0 includes it.
        gp[0] = gp[0] | p[0];

        for (int d = 1; d < 16; d = d * 2) begin
            for (int i = 2 * d - 1; i < 16; i = i + 2 * d) begin
                gp[i] = gp[i] | (pp[i] & gp[i - d]);
                pp[i] = pp[i] & pp[i - d];
            end
        end

        for (int d = 4; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < 16; i = i + 2 * d) begin
                gp[i] = gp[i] | (pp[i] & gp[i - d]);
            end
        end

        diff     = p ^ {gp[14:0], 1'b1};
        borrow_n = gp[15];
    end

endmodule

// File: rtl/seq_divider_16by8.sv
// Sequential restoring divider: DW-bit / VW-bit unsigned, one quotient bit
// per cycle, using the shared Brent-Kung subtractor for each trial subtraction.
module seq_divider_16by8 #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero
);
    import mac_pkg::*;

    localparam int CW = $clog2(DW);

    div_state_t    state, state_nxt;
    logic [DW-1:0] dvd_q;
    logic [DW-1:0] quo_sr;
    logic [VW-1:0] dvs_q;
    logic [VW:0]   rem_q;
    logic [CW-1:0] cnt_q;

    logic [VW:0]      trial;
    logic [VW:0]      rem_nxt;
    logic [SUB_W-1:0] sub_a, sub_b, sub_diff;
    logic             no_borrow;
    logic             unused_bits;

    assign trial = {rem_q[VW-1:0], dvd_q[DW-1]};
    assign sub_a = SUB_W'(trial);
    assign sub_b = SUB_W'(dvs_q);

    bk_sub_16 u_sub (
        .a        (sub_a),
        .b        (sub_b),
        .diff     (sub_diff),
        .borrow_n (no_borrow)
    );

    assign rem_nxt = no_borrow ? sub_diff[VW:0] : trial;

    // R never exceeds the divisor, so its top bit and the upper difference bits carry no information.
    assign unused_bits = ^{sub_diff[SUB_W-1:VW+1], rem_q[VW]};

    assign busy = (state != DIV_ST_IDLE);
    assign done = (state == DIV_ST_DONE);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= DIV_ST_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: next-state defaults to the current state first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            DIV_ST_IDLE: if (start) state_nxt = (divisor == '0) ? DIV_ST_DONE : DIV_ST_RUN;
            DIV_ST_RUN:  if (cnt_q == '0) state_nxt = DIV_ST_DONE;
            DIV_ST_DONE: state_nxt = DIV_ST_IDLE;
            default:     state_nxt = DIV_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_sr    <= '0;
            cnt_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            unique case (state)
                DIV_ST_IDLE: begin
                    if (start) begin
                        dvd_q  <= dividend;
                        dvs_q  <= divisor;
                        rem_q  <= '0;
                        quo_sr <= '0;
                        cnt_q  <= CW'(DW - 1);
                        if (divisor == '0) begin
                            quotient  <= DW'(DIV_ZERO_QUOT);
                            remainder <= dividend[VW-1:0];
                            div_zero  <= 1'b1;
                        end
                    end
                end
                DIV_ST_RUN: begin
                    rem_q  <= rem_nxt;
                    quo_sr <= {quo_sr[DW-2:0], no_borrow};
                    dvd_q  <= {dvd_q[DW-2:0], 1'b0};
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        quotient  <= {quo_sr[DW-2:0], no_borrow};
                        remainder <= rem_nxt[VW-1:0];
                        div_zero  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Self-checking bench for seq_divider_16by8: a cycle-level behavioural model
// compared against the DUT every cycle, plus directed literal checks.
module tb_seq_divider_16by8;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;

    int n_checks = 0;
    int n_errors = 0;

    seq_divider_16by8 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: busy cycles remaining, pending result, visible outputs.
    int          m_left = 0;
    logic [15:0] m_q = '0, p_q = '0;
    logic [7:0]  m_r = '0, p_r = '0;
    logic        m_z = 1'b0;
    int          cyc = 0;
    int          accepts[$];

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_left = 0;
            m_q = '0;
            m_r = '0;
            m_z = 1'b0;
        end else if (m_left == 0) begin
            if (start) begin
                accepts.push_back(cyc);
                if (divisor == 0) begin
                    m_left = 1;
                    m_q = 16'hFFFF;
                    m_r = dividend[7:0];
                    m_z = 1'b1;
                end else begin
                    m_left = 17;
                    p_q = dividend / {8'd0, divisor};
                    p_r = 8'(dividend % {8'd0, divisor});
                end
            end
        end else begin
            m_left--;
            if (m_left == 1) begin
                m_q = p_q;
                m_r = p_r;
                m_z = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", {31'd0, busy}, {31'd0, m_left > 0});
        check("done", {31'd0, done}, {31'd0, m_left == 1});
        check("quotient", {16'd0, quotient}, {16'd0, m_q});
        check("remainder", {24'd0, remainder}, {24'd0, m_r});
        check("div_zero", {31'd0, div_zero}, {31'd0, m_z});
    end

    // Issues one division from idle and waits (bounded) for done.
    task automatic run_div(input logic [15:0] dvd, input logic [7:0] dvs, input bit lit,
                           input logic [15:0] exp_q, input logic [7:0] exp_r);
        int edges;
        bit seen;
        @(negedge clk);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        edges = 0;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            edges++;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            check("done_edge", edges, (dvs == 0) ? 0 : 16);
            if (lit) begin
                check("lit_quotient", {16'd0, quotient}, {16'd0, exp_q});
                check("lit_remainder", {24'd0, remainder}, {24'd0, exp_r});
                check("lit_div_zero", {31'd0, div_zero}, {31'd0, dvs == 0});
            end
        end
    endtask

    initial begin
        int ndone;
        int spurious;
        logic [15:0] rd;
        logic [7:0]  rv;

        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quotient", {16'd0, quotient}, 32'd0);
        check("rst_remainder", {24'd0, remainder}, 32'd0);
        check("rst_div_zero", {31'd0, div_zero}, 32'd0);
        rst = 1'b0;

        run_div(16'h03E8, 8'h07, 1'b1, 16'd142, 8'd6);
        run_div(16'hFFFF, 8'hFF, 1'b1, 16'd257, 8'd0);
        run_div(16'd5, 8'd9, 1'b1, 16'd0, 8'd5);
        run_div(16'h1234, 8'h00, 1'b1, 16'hFFFF, 8'h34);
        run_div(16'hFFFF, 8'h01, 1'b1, 16'hFFFF, 8'h00);
        run_div(16'd0, 8'd5, 1'b1, 16'd0, 8'd0);

        // start held high: only accepts at 18-cycle spacing, busy-time input changes ignored.
        accepts.delete();
        ndone = 0;
        for (int k = 0; k < 57; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                check("held_quotient", {16'd0, quotient}, 32'd33);
                check("held_remainder", {24'd0, remainder}, 32'd1);
            end
            start = (k <= 36);
            if (k % 18 == 0) begin
                dividend = 16'd100;
                divisor  = 8'd3;
            end else begin
                dividend = 16'($urandom);
                divisor  = 8'($urandom);
            end
        end
        start = 1'b0;
        check("held_dones", ndone, 3);
        check("held_accepts", accepts.size(), 3);
        if (accepts.size() == 3) begin
            check("held_gap1", accepts[1] - accepts[0], 18);
            check("held_gap2", accepts[2] - accepts[1], 18);
        end

        // Reset mid-run abandons the operation without a done pulse.
        run_div(16'd50000, 8'd7, 1'b0, '0, '0);
        @(negedge clk);
        dividend = 16'd50001;
        divisor  = 8'd13;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_quotient", {16'd0, quotient}, 32'd0);
        check("midrst_remainder", {24'd0, remainder}, 32'd0);
        spurious = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) spurious++;
        end
        check("midrst_no_done", spurious, 0);
        run_div(16'd200, 8'd10, 1'b1, 16'd20, 8'd0);

        for (int n = 0; n < 2500; n++) begin
            rd = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            rv = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            run_div(rd, rv, 1'b0, '0, '0);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
